// File: rtl/multicycle_alu.sv
// multicycle_alu: handshaked ALU with single-cycle logic/arithmetic ops and
// iterative (one bit per cycle) multiply, unsigned divide and remainder.
//
// Ports:
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   - operation handshake; in_ready high only when idle
//   a, b, control         - operands and 4-bit operation select
//   out_valid / out_ready - result handshake; outputs held until out_ready
//   result, zero, overflow- registered result, result==0, signed ADD/SUB ovf
module multicycle_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000, OP_OR   = 4'b0001, OP_ADD  = 4'b0010, OP_XOR  = 4'b0011,
    OP_SLL  = 4'b0100, OP_SRL  = 4'b0101, OP_SUB  = 4'b0110, OP_SLT  = 4'b0111,
    OP_MUL  = 4'b1000, OP_DIVU = 4'b1010, OP_REMU = 4'b1011, OP_NOR  = 4'b1100
  } op_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;   // product accumulator / partial remainder
  logic [WIDTH-1:0] wrk_q, wrk_d;   // multiplier bits / dividend->quotient
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  // Single-cycle datapath, evaluated directly on the accepted inputs.
  logic [WIDTH-1:0] sum, diff, sc_res;
  logic             sc_ovf, is_multi;

  always_comb begin
    sum    = a + b;
    diff   = a - b;
    sc_res = '0;
    sc_ovf = 1'b0;
    case (control)
      OP_AND: sc_res = a & b;
      OP_OR:  sc_res = a | b;
      OP_XOR: sc_res = a ^ b;
      OP_NOR: sc_res = ~(a | b);
      OP_SLL: sc_res = a << b[SHW-1:0];
      OP_SRL: sc_res = a >> b[SHW-1:0];
      OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = diff;
        sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      default: ;
    endcase
    is_multi = (control == OP_MUL) || (control == OP_DIVU) || (control == OP_REMU);
  end

  // One iteration step. Multiply is MSB-first shift-add; divide is restoring,
  // where the trial subtraction's top bit is the borrow. A zero divisor never
  // borrows, which yields an all-ones quotient and remainder == dividend.
  logic [WIDTH-1:0] mul_nx, rem_nx, quo_nx;
  logic [WIDTH:0]   rem_sh, trial;
  logic             q_bit;

  always_comb begin
    mul_nx = {acc_q[WIDTH-2:0], 1'b0} + (wrk_q[WIDTH-1] ? a_q : '0);
    rem_sh = {acc_q, wrk_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, b_q};
    q_bit  = ~trial[WIDTH];
    rem_nx = q_bit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nx = {wrk_q[WIDTH-2:0], q_bit};
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    ctrl_d   = ctrl_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    wrk_d    = wrk_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d    = a;
          b_d    = b;
          ctrl_d = control;
          cnt_d  = '0;
          if (is_multi) begin
            state_d = BUSY;
            acc_d   = '0;
            wrk_d   = (control == OP_MUL) ? b : a;
          end else begin
            state_d  = DONE;
            result_d = sc_res;
            zero_d   = (sc_res == '0);
            ovf_d    = sc_ovf;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (ctrl_q == OP_MUL) begin
          acc_d = mul_nx;
          wrk_d = {wrk_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = rem_nx;
          wrk_d = quo_nx;
        end
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          ovf_d   = 1'b0;
          if (ctrl_q == OP_MUL) begin
            result_d = mul_nx;
            zero_d   = (mul_nx == '0);
          end else if (ctrl_q == OP_DIVU) begin
            result_d = quo_nx;
            zero_d   = (quo_nx == '0);
          end else begin
            result_d = rem_nx;
            zero_d   = (rem_nx == '0);
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      ctrl_q   <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      wrk_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ctrl_q   <= ctrl_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      wrk_q    <= wrk_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu (WIDTH=32): directed vectors with
// literal expectations plus a cycle-level behavioural model compared every cycle.
module tb_multicycle_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   control = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         zero;
  logic         overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .control(control), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .overflow(overflow)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] m_calc(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    logic [4:0]  sh;
    sh = y[4:0];
    case (c)
      4'd0:  return x & y;
      4'd1:  return x | y;
      4'd2:  return x + y;
      4'd3:  return x ^ y;
      4'd4:  return x << sh;
      4'd5:  return x >> sh;
      4'd6:  return x - y;
      4'd7:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd8:  begin p = {32'd0, x} * {32'd0, y}; return p[31:0]; end
      4'd10: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      4'd11: return (y == 0) ? x : x % y;
      4'd12: return ~(x | y);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_ovf(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    longint s, hi, lo;
    hi = (longint'(1) << 31) - 1;
    lo = -(longint'(1) << 31);
    if (c == 4'd2)      s = longint'($signed(x)) + longint'($signed(y));
    else if (c == 4'd6) s = longint'($signed(x)) - longint'($signed(y));
    else return 1'b0;
    return (s > hi) || (s < lo);
  endfunction

  logic         m_init = 1'b0;
  logic         m_ready, m_valid, m_zero, m_ovf_q, p_ovf;
  logic [W-1:0] m_res, p_res;
  int           m_wait;

  always @(posedge clk) begin
    if (reset) begin
      m_init  <= 1'b1;
      m_ready <= 1'b1;
      m_valid <= 1'b0;
      m_res   <= '0;
      m_zero  <= 1'b1;
      m_ovf_q <= 1'b0;
      m_wait  <= 0;
    end else if (m_init) begin
      if (m_ready && in_valid) begin
        m_ready <= 1'b0;
        if (control == 4'd8 || control == 4'd10 || control == 4'd11) begin
          m_wait <= W;
          p_res  <= m_calc(control, a, b);
          p_ovf  <= 1'b0;
        end else begin
          m_valid <= 1'b1;
          m_res   <= m_calc(control, a, b);
          m_zero  <= (m_calc(control, a, b) == 0);
          m_ovf_q <= m_ovf(control, a, b);
        end
      end else if (m_wait > 0) begin
        m_wait <= m_wait - 1;
        if (m_wait == 1) begin
          m_valid <= 1'b1;
          m_res   <= p_res;
          m_zero  <= (p_res == 0);
          m_ovf_q <= p_ovf;
        end
      end else if (m_valid && out_ready) begin
        m_valid <= 1'b0;
        m_ready <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("cyc_in_ready",  in_ready,  m_ready);
      chk("cyc_out_valid", out_valid, m_valid);
      chk("cyc_result",    result,    m_res);
      chk("cyc_zero",      zero,      m_zero);
      chk("cyc_overflow",  overflow,  m_ovf_q);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic do_op(input string nm, input logic [3:0] c, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] er, input logic ez,
                       input logic eo, input int elat);
    int   n;
    int   lat;
    int   low;
    logic rdy;
    @(posedge clk); #1;
    a = av; b = bv; control = c; in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 100);
    #1 in_valid = 1'b0;
    a = ~av; b = ~bv; control = 4'd2;  // must not disturb the latched operation
    if (!rdy) chk({nm, "_accept_timeout"}, 0, 1);
    lat = 0;
    low = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!in_ready) low++;
    end while (!out_valid && lat < 100);
    chk({nm, "_latency"}, lat, elat);
    chk({nm, "_ready_low"}, low, elat);
    chk({nm, "_result"}, result, er);
    chk({nm, "_zero"}, zero, ez);
    chk({nm, "_ovf"}, overflow, eo);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 1);
    chk("rst_ovf", overflow, 0);
    @(posedge clk); #1 reset = 1'b0;

    do_op("add17",  4'd2,  32'd17, 32'd17, 32'd34, 1'b0, 1'b0, 1);
    do_op("sub17",  4'd6,  32'd17, 32'd17, 32'd0,  1'b1, 1'b0, 1);
    do_op("addovf", 4'd2,  32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1, 1);
    do_op("subovf", 4'd6,  32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1);
    do_op("addwrap",4'd2,  32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1);
    do_op("slt_t",  4'd7,  32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1);
    do_op("slt_f",  4'd7,  32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 1);
    do_op("and",    4'd0,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0, 1);
    do_op("or",     4'd1,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0, 1'b0, 1);
    do_op("xor",    4'd3,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0, 1'b0, 1);
    do_op("nor",    4'd12, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h000F_000F, 1'b0, 1'b0, 1);
    do_op("sll",    4'd4,  32'd1, 32'h24, 32'h10, 1'b0, 1'b0, 1);
    do_op("srl",    4'd5,  32'h8000_0000, 32'd31, 32'd1, 1'b0, 1'b0, 1);
    do_op("illegal",4'd9,  32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 1);
    do_op("mul17",  4'd8,  32'd17, 32'd17, 32'd289, 1'b0, 1'b0, W + 1);
    do_op("mulbig", 4'd8,  32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, 1'b0, W + 1);
    do_op("divu",   4'd10, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, W + 1);
    do_op("remu",   4'd11, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, W + 1);
    do_op("divu0",  4'd10, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, W + 1);
    do_op("remu0",  4'd11, 32'd5, 32'd0, 32'd5, 1'b0, 1'b0, W + 1);

    // Backpressure: hold in DONE for 10 cycles while poking in_valid.
    @(posedge clk); #1 out_ready = 1'b0;
    do_op("bp_add", 4'd2, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = ~in_valid;
      a = $urandom; b = $urandom; control = 4'd8;
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_ready", in_ready, 0);
      chk("bp_result", result, 32'd30);
    end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_still_valid", out_valid, 1);
    @(negedge clk);
    chk("bp_idle_ready", in_ready, 1);
    chk("bp_idle_valid", out_valid, 0);
    chk("bp_held_result", result, 32'd30);

    // Reset during cycle 10 of a multiply.
    @(posedge clk); #1;
    a = 32'd17; b = 32'd17; control = 4'd8; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_result", result, 0);
    chk("mrst_zero", zero, 1);
    do_op("post_rst_add", 4'd2, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal range 4..64).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operands/control valid.
REQ-006 SHALL have port in_ready  output  1  block can accept an operation.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port control  input  4  operation select.
REQ-010 SHALL have port out_valid  output  1  result/flags valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  WIDTH  registered result.
REQ-013 SHALL have port zero  output  1  registered, result == 0.
REQ-014 SHALL have port overflow  output  1  registered signed overflow of ADD/SUB, else 0.

Function
REQ-015 SHALL decode control: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SLT (signed), 1000 MUL (low WIDTH bits of unsigned product), 1010 DIVU, 1011 REMU, 1100 NOR.
REQ-016 SHALL treat every other control code as illegal: result 0, zero 1, overflow 0, single-cycle latency.
REQ-017 SHALL implement FSM states IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-018 SHALL accept an operation on a rising edge with in_valid && in_ready, latching a, b, control.
REQ-019 SHALL, for single-cycle ops (incl. illegal), go IDLE -> DONE at acceptance; out_valid high the next cycle.
REQ-020 SHALL, for MUL/DIVU/REMU, go IDLE -> BUSY, iterate one bit per cycle for exactly WIDTH cycles (shift-add multiply, restoring divide), then BUSY -> DONE; out_valid first high WIDTH+1 cycles after acceptance.
REQ-021 SHALL hold result, zero, overflow, out_valid stable in DONE until out_ready is high; DONE -> IDLE on that edge.
REQ-022 SHALL ignore in_valid and input changes while BUSY or DONE; latched operands are never corrupted.
REQ-023 SHALL use b[SHW-1:0] as shift amount for SLL/SRL; SRL is logical.
REQ-024 SHALL compute overflow for ADD as (a,b same sign, result differs) and SUB as (a,b differ in sign, result sign != a sign); all arithmetic wraps modulo 2^WIDTH.
REQ-025 SHALL return, on DIVU/REMU with b == 0, quotient all-ones and remainder = a, still taking WIDTH cycles.
REQ-026 SHALL set SLT result to 1 if signed a < signed b else 0 (zero-extended).
REQ-027 SHALL keep result, zero, overflow at their DONE values after leaving DONE until the next operation completes.

Reset
REQ-028 SHALL, on reset high at a clock edge, enter IDLE regardless of current state, abandoning any in-flight operation.
REQ-029 SHALL reset result to 0, zero to 1, overflow to 0, out_valid to 0; in_ready 1 from the first cycle after reset deasserts.
REQ-030 SHALL give reset priority over in_valid and out_ready in the same cycle.

Verification
REQ-031 SHALL (WIDTH=32) check ADD a=17,b=17 -> out_valid 1 cycle after accept, result 34, zero 0, overflow 0; SUB 17,17 -> result 0, zero 1.
REQ-032 SHALL check ADD a=0x7FFFFFFF,b=1 -> result 0x80000000, overflow 1; SUB a=0x80000000,b=1 -> overflow 1; SLT a=0xFFFFFFFF,b=1 -> 1.
REQ-033 SHALL check MUL 17*17 -> in_ready low 33 cycles, out_valid exactly 33 cycles after accept, result 289; MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE.
REQ-034 SHALL check DIVU 100/7 -> 14, REMU 100%7 -> 2, DIVU 5/0 -> 0xFFFFFFFF, REMU 5%0 -> 5, each 33-cycle latency.
REQ-035 SHALL check backpressure: out_ready low 10 cycles in DONE -> outputs stable, in_valid pulses ignored, out_ready high -> IDLE next cycle.
REQ-036 SHALL check reset asserted on cycle 10 of MUL -> cycle after: in_ready 1, out_valid 0, result 0, zero 1; new ADD 2+3 -> 5.
